wr_arb_sched: RTL
=================

WR_ARB_SCHED -- requirements
Module: wr_arb_sched

Interface
REQ-001 Parameters: none; master count fixed at 3 by package constant WR_ARB_NUM_M.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rstn  input  1  asynchronous active-low reset.
REQ-004 AWVALID_M0/AWVALID_M1/AWVALID_M2  input  1 each  write-address request per master.
REQ-005 AWREADY_M0/AWREADY_M1/AWREADY_M2  output  1 each  AW acceptance back to each master.
REQ-006 AWVALID_S  output  1  AW valid toward the decoded slave path.
REQ-007 AWREADY_S  input  1  AW ready from the decoded slave.
REQ-008 AW_GNT  output  3  one-hot AW mux select; nonzero only in AW state.
REQ-009 WVALID_SEL, WLAST_SEL  input  1 each  W valid and last of the muxed owning master.
REQ-010 WREADY_S  input  1  W ready from the slave.
REQ-011 WREADY_OWN  output  1  WREADY_S gated to the owner; forced 0 outside W state.
REQ-012 BVALID_S  input  1  B valid from the slave.
REQ-013 BREADY_SEL  input  1  B ready of the owning master.
REQ-014 W_GNT  output  3  one-hot W/B routing owner; nonzero in AW, W and B states.
REQ-015 BUSY  output  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have four states: IDLE, AW, W, B; one write transaction is in flight at a time.
REQ-017 IDLE: any AWVALID_Mx high -> grant registered, AW next cycle; no request -> stay IDLE.
REQ-018 Request latency SHALL be 1 cycle: a request sampled at edge N drives AWVALID_S from cycle N+1.
REQ-019 AW: AWVALID_S = AWVALID of the granted master; AWREADY_Mg = AWREADY_S; the other AWREADY_Mx = 0.
REQ-020 AW -> W on AWVALID_S & AWREADY_S; otherwise hold, with the grant unchanged even if the granted master drops AWVALID.
REQ-021 W: WREADY_OWN = WREADY_S; W -> B on WVALID_SEL & WREADY_S & WLAST_SEL; non-last beats SHALL not change state.
REQ-022 B: B -> IDLE on BVALID_S & BREADY_SEL; the grant and W_GNT SHALL clear on the same edge.
REQ-023 A new arbitration SHALL occur only in IDLE, so back-to-back writes have 1 idle cycle between B handshake and next AWVALID_S.
REQ-024 AW_GNT and W_GNT SHALL be one-hot or zero at all times.
REQ-025 A W beat presented before the AW handshake SHALL be stalled (WREADY_OWN = 0), not dropped.

Reset
REQ-026 On rstn low: state = IDLE; AW_GNT = W_GNT = 0; AWVALID_S = AWREADY_Mx = WREADY_OWN = BUSY = 0; last-grant pointer = M2.
REQ-027 A reset mid-transaction SHALL abandon it with no completion pulse; after release, the first grant follows REQ-026 pointer rules.

Configuration
REQ-028 With WR_ARB_RR_EN defined: round-robin; search starts at the master after the last granted one; the pointer updates on each IDLE->AW transition.
REQ-029 Without WR_ARB_RR_EN: fixed priority M0 > M1 > M2; the pointer is unused and removed.

Structure
REQ-030 The package SHALL hold WR_ARB_NUM_M, the wr_arb_state_t enum (IDLE/AW/W/B) and the one-hot grant type wr_gnt_t.
REQ-031 The request picker SHALL be a separate combinational sub-module wr_rr_pick (req, last pointer, RR enable -> one-hot pick); all state lives in wr_arb_sched.

Verification
REQ-032 Reset, then M1 only requests; AWREADY_S=1 -> AWVALID_S at cycle+1, AW_GNT=3'b010, AWREADY_M1 pulses once, state AW->W.
REQ-033 In W, 4 beats (WLAST on 4th), WREADY_S=1 -> W->B after beat 4 only; then BVALID_S=BREADY_SEL=1 -> IDLE, W_GNT=0, BUSY=0.
REQ-034 RR build, all three request continuously -> grant order M0, M1, M2, M0; without macro -> M0 on every grant.
REQ-035 AWREADY_S=0 for 5 cycles while M0 granted and M2 requests -> AW_GNT stays 3'b001, AWREADY_M2=0 throughout.
REQ-036 WVALID_SEL=1 during AW state -> WREADY_OWN=0; beat accepted only after entering W.
REQ-037 rstn low during B state -> next cycle all outputs 0, state IDLE; a pending M1 request re-granted 1 cycle after release.

Source files
------------

// File: rtl/wr_arb_sched_pkg.sv
// wr_arb_sched_pkg
// Shared types and constants for the write-channel arbiter/scheduler.
//   WR_ARB_NUM_M     number of write masters (fixed at 3)
//   wr_arb_state_t   scheduler FSM states IDLE/AW/W/B
//   wr_gnt_t         one-hot grant vector, one bit per master
//   WR_GNT_LAST_RST  reset value of the round-robin last-grant pointer (M2)
package wr_arb_sched_pkg;

    localparam int WR_ARB_NUM_M = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AW   = 2'd1,
        W    = 2'd2,
        B    = 2'd3
    } wr_arb_state_t;

    typedef logic [WR_ARB_NUM_M-1:0] wr_gnt_t;

    // Pointing at M2 after reset makes the first round-robin search start at M0.
    localparam wr_gnt_t WR_GNT_LAST_RST = wr_gnt_t'(1 << (WR_ARB_NUM_M - 1));

endpackage

// File: rtl/wr_arb_sched_rr_pick.sv
// wr_rr_pick
// Combinational request picker. Returns a one-hot pick among the requesting
// masters. With i_rr_en set the search starts at the master after the one
// flagged in i_last (round-robin); with i_rr_en clear the search always
// starts at M0, which gives fixed priority M0 > M1 > M2.
// Ports:
//   i_req    requesting masters (bit per master)
//   i_last   one-hot last-granted master
//   i_rr_en  1 = round-robin, 0 = fixed priority
//   o_pick   one-hot chosen master, zero when nobody requests
module wr_rr_pick
    import wr_arb_sched_pkg::*;
(
    input  wr_gnt_t i_req,
    input  wr_gnt_t i_last,
    input  logic    i_rr_en,
    output wr_gnt_t o_pick
);

    logic [1:0] w_start;
    logic       w_found;

    always_comb begin
        w_start = 2'd0;
        if (i_rr_en) begin
            if (i_last[0])      w_start = 2'd1;
            else if (i_last[1]) w_start = 2'd2;
            else                w_start = 2'd0;
        end
    end

    always_comb begin
        o_pick  = '0;
        w_found = 1'b0;
        for (int k = 0; k < WR_ARB_NUM_M; k++) begin
            int idx;
            idx = (int'(w_start) + k) % WR_ARB_NUM_M;
            if (!w_found && i_req[idx]) begin
                o_pick[idx] = 1'b1;
                w_found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wr_arb_sched.sv
// wr_arb_sched
// Write-channel scheduler for three AXI-style masters sharing one slave path.
// One write is in flight at a time: the FSM walks IDLE -> AW -> W -> B -> IDLE
// and a new arbitration only happens in IDLE.
// Optional feature: define WR_ARB_RR_EN for round-robin arbitration; without
// it, arbitration is fixed priority M0 > M1 > M2 and no pointer is kept.
// Ports:
//   clk, rstn                      clock, asynchronous active-low reset
//   AWVALID_M0..2 / AWREADY_M0..2  per-master AW handshake
//   AWVALID_S / AWREADY_S          AW handshake toward the slave path
//   AW_GNT                         one-hot AW mux select (AW state only)
//   WVALID_SEL, WLAST_SEL          W valid/last of the owning master (muxed)
//   WREADY_S / WREADY_OWN          slave W ready / same gated to the owner
//   BVALID_S, BREADY_SEL           B handshake of slave and owning master
//   W_GNT                          one-hot W/B routing owner (AW, W, B states)
//   BUSY                           high whenever not IDLE
//   o_dbg_state                    current FSM state for observation
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never waits on ready, and ready is only ever passed
// through (gated by ownership and state), never registered.
module wr_arb_sched
    import wr_arb_sched_pkg::*;
(
    input  logic          clk,
    input  logic          rstn,
    input  logic          AWVALID_M0,
    input  logic          AWVALID_M1,
    input  logic          AWVALID_M2,
    output logic          AWREADY_M0,
    output logic          AWREADY_M1,
    output logic          AWREADY_M2,
    output logic          AWVALID_S,
    input  logic          AWREADY_S,
    output logic [2:0]    AW_GNT,
    input  logic          WVALID_SEL,
    input  logic          WLAST_SEL,
    input  logic          WREADY_S,
    output logic          WREADY_OWN,
    input  logic          BVALID_S,
    input  logic          BREADY_SEL,
    output logic [2:0]    W_GNT,
    output logic          BUSY,
    output wr_arb_state_t o_dbg_state
);

    wr_arb_state_t r_state;
    wr_arb_state_t w_state_nxt;
    wr_gnt_t       r_gnt;
    wr_gnt_t       w_gnt_nxt;
    wr_gnt_t       w_req;
    wr_gnt_t       w_pick;
    wr_gnt_t       w_last;
    logic          w_rr_en;
    logic          w_aw_hs;

    assign w_req = {AWVALID_M2, AWVALID_M1, AWVALID_M0};

`ifdef WR_ARB_RR_EN
    wr_gnt_t r_last;

    assign w_rr_en = 1'b1;
    assign w_last  = r_last;

    // Pointer only moves when a grant is taken (IDLE -> AW).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_last <= WR_GNT_LAST_RST;
        end else if (r_state == IDLE && (|w_req)) begin
            r_last <= w_pick;
        end
    end
`else
    assign w_rr_en = 1'b0;
    assign w_last  = '0;
`endif

    wr_rr_pick u_pick (
        .i_req   (w_req),
        .i_last  (w_last),
        .i_rr_en (w_rr_en),
        .o_pick  (w_pick)
    );

    // AWVALID_S follows the granted master live; the grant itself is held
    // even if that master drops its request before the handshake.
    assign AWVALID_S = (r_state == AW) && (|(r_gnt & w_req));
    assign w_aw_hs   = AWVALID_S && AWREADY_S;

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        case (r_state)
            IDLE: begin
                if (|w_req) begin
                    w_state_nxt = AW;
                    w_gnt_nxt   = w_pick;
                end
            end
            AW: begin
                if (w_aw_hs) begin
                    w_state_nxt = W;
                end
            end
            W: begin
                // Non-last beats transfer without changing state.
                if (WVALID_SEL && WREADY_S && WLAST_SEL) begin
                    w_state_nxt = B;
                end
            end
            B: begin
                if (BVALID_S && BREADY_SEL) begin
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_gnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
        end
    end

    assign AWREADY_M0 = (r_state == AW) && r_gnt[0] && AWREADY_S;
    assign AWREADY_M1 = (r_state == AW) && r_gnt[1] && AWREADY_S;
    assign AWREADY_M2 = (r_state == AW) && r_gnt[2] && AWREADY_S;

    assign AW_GNT = (r_state == AW) ? r_gnt : '0;
    assign W_GNT  = (r_state != IDLE) ? r_gnt : '0;

    // W beats offered early (still in AW) are stalled, not dropped.
    assign WREADY_OWN = (r_state == W) && WREADY_S;

    assign BUSY        = (r_state != IDLE);
    assign o_dbg_state = r_state;

endmodule
